voxel_ram_loader: RTL and testbench
===================================

Name: voxel_ram_loader

Overview:
- Write-side master for the voxel occupancy RAM.
- Accepts a command (CLEAR or LOAD) and drives the RAM's 1-bit synchronous write port.
- LOAD unpacks a host byte stream (valid/ready) into per-voxel writes, LSB first, at sequential addresses from 0. CLEAR zero-fills the whole array.
- Sits between the host/config interface (UART/SPI byte front end) and voxel_ram. Traversal reads are not blocked by this block; arbitration is outside it.

Parameters:
- ADDR_W, 15, voxel address width; must match the RAM's write address width.
- DEPTH, 32768, voxels written per command; power of 2, multiple of 8, <= 2**ADDR_W. Benches use 64.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_op  in  1  0 = CLEAR, 1 = LOAD
- cmd_ready  out  1  high only in IDLE
- abort  in  1  cancel any in-progress command
- in_valid  in  1  host byte valid
- in_data  in  8  8 voxels, bit0 = lowest address
- in_ready  out  1  byte accepted when in_valid && in_ready
- wr_en  out  1  to RAM write enable
- wr_addr  out  ADDR_W  to RAM write address
- wr_data  out  1  to RAM write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset values: state IDLE; wr_en, wr_addr, wr_data, busy, done and all counters are 0. cmd_ready is 1 from the first cycle after reset deasserts; in_ready is 0.
- wr_en, wr_addr and wr_data come from state/counter/shift registers only. There is no combinational path from any input.
- in_ready = (state == LOAD_WAIT) && !abort.
- cmd_ready = (state == IDLE).
- States:
  - IDLE: on cmd_valid, go to CLEAR (op 0) or LOAD_WAIT (op 1). addr counter := 0.
  - CLEAR: wr_en = 1, wr_data = 0, wr_addr = addr. Increment addr each cycle. After the write to DEPTH-1, go to DONE.
  - LOAD_WAIT: wr_en = 0. On byte handshake, shreg := in_data, bitcnt := 0, go to SHIFT.
  - SHIFT: wr_en = 1, wr_data = shreg[0], wr_addr = addr. Each cycle shreg >>= 1, bitcnt++, addr++.
    - After bitcnt 7: go to DONE if that write was to DEPTH-1, else go to LOAD_WAIT.
  - DONE: done = 1 for exactly one cycle, busy = 1, then IDLE.
- Latency:
  - CLEAR accepted at edge N: writes occupy cycles N+1 .. N+DEPTH, addresses 0..DEPTH-1. done is high in cycle N+DEPTH+1.
  - LOAD: each accepted byte produces 8 consecutive write cycles starting the cycle after the handshake. Peak rate is 9 cycles per byte.
- Address arithmetic: addr is ADDR_W bits and increments by 1. Termination is an explicit compare to DEPTH-1, never wrap detection. addr never wraps inside a command.
- Stall: in LOAD_WAIT with in_valid low, remain indefinitely with wr_en = 0. No timeout.
- Abort:
  - When abort is sampled high in any non-IDLE state, next state is IDLE. done is not pulsed and addr is cleared.
  - A write presented in the abort cycle still occurs; at most one write after abort is asserted.
  - Abort in IDLE is ignored. Abort and cmd_valid together in IDLE: the command is accepted.
  - Abort in LOAD_WAIT forces in_ready low, so no byte is consumed.
- cmd_valid outside IDLE is ignored, since cmd_ready = 0. in_valid outside LOAD_WAIT is ignored.
- Reset mid-command: immediate return to reset values. RAM contents are left partially written; this is not this block's concern.
- cmd_op values are fully decoded; there is no illegal op.

Decomposition:
- Shared package voxel_pkg:
  - VOX_ADDR_W = 15 and VOX_DEPTH = 32768, also used by voxel_ram users.
  - Enum loader_op_e {OP_CLEAR, OP_LOAD}.
  - Enum loader_state_e {IDLE, CLEAR, LOAD_WAIT, SHIFT, DONE}.
- One sub-module is natural: voxel_byte_serializer.
  - Holds the 8-bit shift register and 3-bit bit counter.
  - Ports: load, din[7:0], step, bit_out, last.
- The FSM and address counter stay in voxel_ram_loader.

Test Plan (DEPTH = 64, paired with a voxel_ram instance):
- CLEAR after reset: cmd_op = 0 at edge N -> wr_en high cycles N+1..N+64, addr 0..63, wr_data 0; done single pulse at N+65; every RAM bit reads 0; cmd_ready high at N+66.
- LOAD 8 bytes 0x01, 0x80, 0xFF, 0x00, 0xA5, 0x5A, 0x3C, 0xC3, back-to-back valid -> addr 0 = 1, addr 15 = 1, addr 16..23 = 1, addr 32 = 1, addr 33 = 0; 72 busy cycles before done; RAM readback matches bit-for-bit.
- LOAD with in_valid gaps of 0, 3 and 20 cycles between bytes -> wr_en low throughout each gap; identical RAM image to the gap-free run; in_ready high only in LOAD_WAIT.
- Abort during byte 3, SHIFT bitcnt 4 (addr 20) -> at most one more write (addr 20); no done; state IDLE next cycle; addr 21..63 unchanged from the prior CLEAR.
- Abort with in_valid high in LOAD_WAIT -> in_ready = 0, byte not consumed, no write; cmd_valid sampled in the abort cycle is not accepted; fresh CLEAR afterwards completes normally.
- Reset asserted mid-CLEAR at addr 30 -> next cycle wr_en = 0, busy = 0, done = 0; no done pulse follows; cmd_valid during busy ignored (cmd_ready = 0).

Source files
------------

// File: rtl/voxel_pkg.sv
// Shared definitions for the voxel occupancy RAM and the blocks that use it.
//   VOX_ADDR_W / VOX_DEPTH : geometry of the voxel RAM (one bit per voxel)
//   loader_op_e            : command opcode accepted by voxel_ram_loader
//   loader_state_e         : voxel_ram_loader FSM states
package voxel_pkg;

    localparam int VOX_ADDR_W = 15;
    localparam int VOX_DEPTH  = 32768;

    typedef enum logic {
        OP_CLEAR = 1'b0,
        OP_LOAD  = 1'b1
    } loader_op_e;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_WAIT,
        SHIFT,
        DONE
    } loader_state_e;

endpackage

// File: rtl/voxel_byte_serializer.sv
// Byte-to-bit serializer for the voxel RAM loader.
// Captures one host byte and presents it one bit per step, LSB first.
//   clock, reset : system clock, synchronous active-high reset
//   load         : capture din and restart the bit counter
//   din[7:0]     : byte to serialize (bit0 goes out first)
//   step         : shift the register right by one and count the bit
//   bit_out      : bit currently presented (shreg[0])
//   last         : the bit currently presented is bit 7 of the byte
module voxel_byte_serializer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       step,
    output logic       bit_out,
    output logic       last
);

    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if (load) begin
            shreg_d  = din;
            bitcnt_d = 3'd0;
        end else if (step) begin
            shreg_d  = {1'b0, shreg_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make every flop update from pre-edge values, independent of statement order.
        if (reset) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign bit_out = shreg_q[0];
    assign last    = (bitcnt_q == 3'd7);

endmodule

// File: rtl/voxel_ram_loader.sv
// Write-side master for the voxel occupancy RAM.
// CLEAR zero-fills DEPTH voxels; LOAD unpacks host bytes (LSB first) into
// sequential 1-bit writes starting at address 0.
//   clock, reset          : system clock, synchronous active-high reset
//   cmd_valid/cmd_op      : command request (0 = CLEAR, 1 = LOAD)
//   cmd_ready             : high only while idle
//   abort                 : cancel the command in progress (no done pulse)
//   in_valid/in_data      : host byte stream, 8 voxels per byte
//   in_ready              : byte consumed when in_valid && in_ready
//   wr_en/wr_addr/wr_data : RAM write port, driven from registers only
//   busy                  : high whenever a command is in progress
//   done                  : one-cycle pulse on normal completion
module voxel_ram_loader
    import voxel_pkg::*;
#(
    parameter int ADDR_W = VOX_ADDR_W,
    parameter int DEPTH  = VOX_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic              cmd_op,
    output logic              cmd_ready,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              busy,
    output logic              done
);

    // Termination is an explicit compare against the final address, so the
    // counter is never relied on to wrap (DEPTH may equal 2**ADDR_W).
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic byte_take;
    logic ser_step;
    logic ser_bit;
    logic ser_last;
    logic at_last;

    assign at_last = (addr_q == LAST_ADDR);

    voxel_byte_serializer u_serializer (
        .clock   (clock),
        .reset   (reset),
        .load    (byte_take),
        .din     (in_data),
        .step    (ser_step),
        .bit_out (ser_bit),
        .last    (ser_last)
    );

    // State and address registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and address update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = (loader_op_e'(cmd_op) == OP_LOAD) ? LOAD_WAIT : CLEAR;
                    addr_d  = '0;
                end
            end
            CLEAR: begin
                if (at_last) begin
                    state_d = DONE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            LOAD_WAIT: begin
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // DEPTH is a multiple of 8, so the final address always
                // coincides with bit 7 of a byte.
                if (ser_last && at_last) begin
                    state_d = DONE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (ser_last) begin
                        state_d = LOAD_WAIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase

        // Abort overrides everything outside IDLE; the write already on the
        // port this cycle still lands, nothing after it does.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            addr_d  = '0;
        end
    end

    // Outputs: the write port decodes registered state only; only the
    // handshake signals look at inputs.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        in_ready  = (state_q == LOAD_WAIT) && !abort;
        byte_take = (state_q == LOAD_WAIT) && !abort && in_valid;
        ser_step  = (state_q == SHIFT);
        wr_en     = (state_q == CLEAR) || (state_q == SHIFT);
        wr_addr   = addr_q;
        wr_data   = (state_q == SHIFT) && ser_bit;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_voxel_ram_loader.sv
// Self-checking bench for voxel_ram_loader (DEPTH = 64).
// Stimulus tasks script each cycle and queue what the outputs must be in
// that cycle; one compare process checks the queue against the DUT on the
// falling edge. A shadow RAM captures the DUT writes and is compared with a
// model image built from the command/byte rules.
module tb_voxel_ram_loader;

    localparam int ADDR_W = 15;
    localparam int DEPTH  = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_op = 1'b0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              cmd_ready;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              busy;
    logic              done;

    voxel_ram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit we;
        int addr;
        bit wd;
        bit bsy;
        bit dn;
        bit cr;
        bit ir;
        bit chk_addr;
    } exp_t;

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               busy_cnt = 0;
    logic [DEPTH-1:0] dut_ram;
    logic [DEPTH-1:0] model_ram;
    logic [7:0]       ld_bytes[8];
    int               ld_gaps[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t e_idle();
        exp_t e = '{default: 0};
        e.cr = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_reset();
        exp_t e = e_idle();
        e.chk_addr = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_wait(input bit ir);
        exp_t e = '{default: 0};
        e.bsy = 1'b1;
        e.ir  = ir;
        return e;
    endfunction

    function automatic exp_t e_done();
        exp_t e = '{default: 0};
        e.bsy = 1'b1;
        e.dn  = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_write(input int a, input bit d);
        exp_t e = '{default: 0};
        e.we   = 1'b1;
        e.addr = a;
        e.wd   = d;
        e.bsy  = 1'b1;
        return e;
    endfunction

    // Shadow of the voxel RAM write port.
    always @(posedge clock) begin
        if (wr_en === 1'b1) dut_ram[wr_addr[5:0]] <= wr_data;
    end

    // Single compare process: one queued expectation per scripted cycle.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_en",     64'(wr_en),     64'(e.we));
            check("busy",      64'(busy),      64'(e.bsy));
            check("done",      64'(done),      64'(e.dn));
            check("cmd_ready", 64'(cmd_ready), 64'(e.cr));
            check("in_ready",  64'(in_ready),  64'(e.ir));
            if (e.we || e.chk_addr) check("wr_addr", 64'(wr_addr), 64'(e.addr));
            if (e.we) check("wr_data", 64'(wr_data), 64'(e.wd));
        end
    end

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        if (busy === 1'b1 && done !== 1'b1) busy_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear(input bit abort_in_idle, input int dup_cmd_at, input int reset_at);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        abort     = abort_in_idle;
        cyc(e_idle());
        cmd_valid = 1'b0;
        abort     = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            cmd_valid = (dup_cmd_at >= 0) && (a == dup_cmd_at || a == dup_cmd_at + 1);
            cmd_op    = 1'b1;
            if (a == reset_at) reset = 1'b1;
            cyc(e_write(a, 1'b0));
            model_ram[a] = 1'b0;
            if (a == reset_at) begin
                reset     = 1'b0;
                cmd_valid = 1'b0;
                cyc(e_reset());
                return;
            end
        end
        cmd_valid = 1'b0;
        cyc(e_done());
    endtask

    task automatic do_load(input bit hold_valid, input int abort_at);
        int a;
        busy_cnt  = 0;
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cyc(e_idle());
        cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b0;
            for (int g = 0; g < ld_gaps[k]; g++) cyc(e_wait(1'b1));
            in_valid = 1'b1;
            in_data  = ld_bytes[k];
            cyc(e_wait(1'b1));
            in_valid = hold_valid;
            for (int j = 0; j < 8; j++) begin
                a     = 8 * k + j;
                abort = (a == abort_at);
                cyc(e_write(a, ld_bytes[k][j]));
                model_ram[a] = ld_bytes[k][j];
                if (a == abort_at) begin
                    abort    = 1'b0;
                    in_valid = 1'b0;
                    cyc(e_idle());
                    return;
                end
            end
        end
        in_valid = 1'b0;
        cyc(e_done());
    endtask

    task automatic set_pattern();
        ld_bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'hC3};
        ld_gaps  = '{0, 0, 0, 0, 0, 0, 0, 0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values.
        reset = 1'b1;
        @(posedge clock);
        #1;
        cyc(e_reset());
        cyc(e_reset());
        reset = 1'b0;
        cyc(e_idle());

        // CLEAR after reset: 64 zero writes, done one cycle later, then idle.
        do_clear(1'b0, -1, -1);
        cyc(e_idle());
        check("model_clear_image", 64'(model_ram), 64'h0);
        check("ram_after_clear", 64'(dut_ram), 64'(model_ram));

        // LOAD, back-to-back bytes, in_valid held high through SHIFT.
        set_pattern();
        do_load(1'b1, -1);
        check("load_busy_cycles", 64'(busy_cnt), 64'd72);
        cyc(e_idle());
        check("model_addr0",      64'(model_ram[0]),     64'd1);
        check("model_addr15",     64'(model_ram[15]),    64'd1);
        check("model_addr16_23",  64'(model_ram[23:16]), 64'hFF);
        check("model_addr32",     64'(model_ram[32]),    64'd1);
        check("model_addr33",     64'(model_ram[33]),    64'd0);
        check("model_load_image", 64'(model_ram), 64'hC33C5AA500FF8001);
        check("ram_after_load",   64'(dut_ram),   64'(model_ram));

        // Same LOAD with 0/3/20-cycle gaps on a freshly cleared array.
        do_clear(1'b0, -1, -1);
        cyc(e_idle());
        set_pattern();
        ld_gaps = '{0, 0, 3, 20, 0, 3, 20, 3};
        do_load(1'b0, -1);
        check("gap_busy_cycles", 64'(busy_cnt), 64'd121);
        cyc(e_idle());
        check("ram_gap_load", 64'(dut_ram), 64'hC33C5AA500FF8001);

        // Abort in SHIFT at address 20 (third byte, bit 4).
        do_clear(1'b0, -1, -1);
        cyc(e_idle());
        ld_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        ld_gaps  = '{0, 0, 0, 0, 0, 0, 0, 0};
        do_load(1'b0, 20);
        cyc(e_idle());
        cyc(e_idle());
        check("model_abort_image", 64'(model_ram), 64'h1FFFFF);
        check("ram_after_abort",   64'(dut_ram),   64'(model_ram));

        // Abort in LOAD_WAIT with a byte and a command offered.
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cyc(e_idle());
        cmd_valid = 1'b0;
        cyc(e_wait(1'b1));
        in_valid  = 1'b1;
        in_data   = 8'h00;
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cyc(e_wait(1'b0));
        in_valid  = 1'b0;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        cyc(e_idle());
        cyc(e_idle());
        check("ram_after_wait_abort", 64'(dut_ram), 64'h1FFFFF);

        // Fresh CLEAR, with abort raised alongside the command in IDLE.
        do_clear(1'b1, -1, -1);
        cyc(e_idle());
        check("ram_after_clear2", 64'(dut_ram), 64'h0);

        // Reload the pattern, then reset mid-CLEAR at address 30 with a
        // stray command offered while busy.
        set_pattern();
        do_load(1'b0, -1);
        cyc(e_idle());
        do_clear(1'b0, 10, 30);
        repeat (5) cyc(e_idle());
        check("model_reset_image", 64'(model_ram), 64'hC33C5AA500000000);
        check("ram_after_reset",   64'(dut_ram),   64'(model_ram));

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
